nav_arbiter: RTL and testbench
==============================

NAV_ARBITER -- requirements
Module: nav_arbiter

Interface
REQ-001 Parameter TMO_CYC, default 24'd5_000_000, WAIT-state timeout in clk cycles (used only with NAV_TMO_EN).
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 r0_hdng_req  input  1  remote-command requester heading-change pulse.
REQ-005 r0_mv_req  input  1  remote-command requester forward-move pulse.
REQ-006 r0_hdng  input  12 signed  remote requester desired heading, sampled with r0_hdng_req.
REQ-007 r1_hdng_req, r1_mv_req, r1_hdng  input  1/1/12 signed  maze-solver requester, same meaning as r0_*.
REQ-008 mv_cmplt  input  1  navigation unit completion pulse.
REQ-009 strt_hdng  output  1  one-cycle heading start to navigation unit.
REQ-010 strt_mv  output  1  one-cycle move start to navigation unit.
REQ-011 dsrd_hdng  output  12 signed  heading presented to navigation unit.
REQ-012 r0_done, r1_done  output  1  one-cycle completion pulse to the owning requester.
REQ-013 gnt  output  2  one-hot current owner (01=r0, 10=r1, 00=none).
REQ-014 busy  output  1  high in ISSUE and WAIT.
REQ-015 nav_err  output  1  one-cycle timeout pulse.

Function
REQ-016 Per requester, separate pending bits for heading and move; set on the corresponding request pulse; heading pulse also stores rX_hdng.
REQ-017 Repeat pulse on an already-pending bit: stays single pending; stored heading overwritten with newest value.
REQ-018 Pulse arriving in the same cycle the pending bit is cleared by issue: set wins (request re-queued).
REQ-019 FSM states IDLE, ISSUE, WAIT; reset to IDLE.
REQ-020 IDLE: any pending bit -> select owner (r0 fixed priority over r1), within owner heading before move; register gnt, command type, and dsrd_hdng (heading commands only); clear selected pending bit; -> ISSUE.
REQ-021 ISSUE: strt_hdng or strt_mv high exactly one cycle per command type; -> WAIT.
REQ-022 WAIT: mv_cmplt -> owner's rX_done pulses next cycle, gnt cleared, -> IDLE.
REQ-023 Latency: request pulse at cycle N -> strt_* high at cycle N+2 when idle with nothing else pending.
REQ-024 Back-to-back: mv_cmplt at cycle M with work pending -> next strt_* at M+2.
REQ-025 mv_cmplt in IDLE or ISSUE ignored; no done pulse.
REQ-026 Grant non-preemptive: r0 requests during r1 ownership wait until WAIT exits.
REQ-027 dsrd_hdng holds last issued heading; unchanged by move commands.
REQ-028 Heading values are passed unmodified; no range checking.

Reset
REQ-029 Reset: state IDLE, all pending bits and stored headings 0, dsrd_hdng 12'h000, gnt 2'b00, strt_hdng/strt_mv/busy/r0_done/r1_done/nav_err 0.
REQ-030 Reset mid-operation discards all pending and in-flight commands; no done pulse after release.

Configuration
REQ-031 Macro NAV_TMO_EN defined: counter clears on ISSUE entry, increments in WAIT; reaching TMO_CYC-1 without mv_cmplt -> nav_err pulse, no rX_done, gnt cleared, -> IDLE.
REQ-032 mv_cmplt in the same cycle as terminal count: completion wins, no nav_err.
REQ-033 Macro undefined: no counter, nav_err tied 0, WAIT indefinite.

Structure
REQ-034 Package nav_arb_pkg: state enum, command-type enum (CMD_HDNG, CMD_MV), gnt encodings, heading constants NORTH 12'h000, WEST 12'h3FF, SOUTH 12'h7FF, EAST 12'hC00.
REQ-035 Sub-module nav_req_latch: one requester's pending bits and stored heading; instantiated twice.

Verification
REQ-036 r1_hdng_req with r1_hdng=12'h3FF at cycle 10 -> strt_hdng at 12, dsrd_hdng=12'h3FF, gnt=10; mv_cmplt at 20 -> r1_done at 21.
REQ-037 r0_mv_req and r1_mv_req same cycle -> r0 served first; r1 strt_mv two cycles after r0's mv_cmplt.
REQ-038 r1_hdng_req and r1_mv_req same cycle -> strt_hdng first, strt_mv only after that mv_cmplt.
REQ-039 r0_hdng_req with 12'h7FF then 12'hC00 during r1 ownership -> one heading command, dsrd_hdng=12'hC00.
REQ-040 NAV_TMO_EN, TMO_CYC=100, no mv_cmplt -> nav_err 100 cycles after ISSUE exit, no done, IDLE; macro off -> stays in WAIT.
REQ-041 rst_n low during WAIT with pending r0 move -> all outputs at reset values; no strt_* after release.

Source files
------------

// File: rtl/nav_arb_pkg.sv
// Shared types and constants for the navigation command arbiter.
package nav_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int HDNG_W  = 12;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {CMD_HDNG, CMD_MV} cmd_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_R0   = 2'b01;
  localparam logic [1:0] GNT_R1   = 2'b10;

  localparam logic signed [HDNG_W-1:0] NORTH = 12'h000;
  localparam logic signed [HDNG_W-1:0] WEST  = 12'h3FF;
  localparam logic signed [HDNG_W-1:0] SOUTH = 12'h7FF;
  localparam logic signed [HDNG_W-1:0] EAST  = 12'hC00;

  // One requester's pulse interface, bundled for the latch array.
  typedef struct packed {
    logic                     hdng_req;
    logic                     mv_req;
    logic signed [HDNG_W-1:0] hdng;
  } req_t;

endpackage

// File: rtl/nav_req_latch.sv
// Pending heading/move bits plus stored heading for a single requester.
// A new pulse wins over a same-cycle clear so a request is never lost.
module nav_req_latch
  import nav_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  req_t                     req,
  input  logic                     clr_hdng,
  input  logic                     clr_mv,
  output logic                     hdng_pend,
  output logic                     mv_pend,
  output logic signed [HDNG_W-1:0] hdng_q
);

  // Heading pending bit and stored heading; newest heading overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdng_pend <= 1'b0;
      hdng_q    <= '0;
    end else if (req.hdng_req) begin
      hdng_pend <= 1'b1;
      hdng_q    <= req.hdng;
    end else if (clr_hdng) begin
      hdng_pend <= 1'b0;
    end
  end

  // Move pending bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          mv_pend <= 1'b0;
    else if (req.mv_req) mv_pend <= 1'b1;
    else if (clr_mv)     mv_pend <= 1'b0;
  end

endmodule

// File: rtl/nav_arbiter.sv
// Arbitrates heading/move commands from two requesters onto one navigation
// unit. r0 has fixed priority; grants are held until the unit completes.
// Optional WAIT timeout enabled by defining NAV_TMO_EN.
module nav_arbiter
  import nav_arb_pkg::*;
#(
  parameter logic [23:0] TMO_CYC = 24'd5_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     r0_hdng_req,
  input  logic                     r0_mv_req,
  input  logic signed [HDNG_W-1:0] r0_hdng,
  input  logic                     r1_hdng_req,
  input  logic                     r1_mv_req,
  input  logic signed [HDNG_W-1:0] r1_hdng,
  input  logic                     mv_cmplt,
  output logic                     strt_hdng,
  output logic                     strt_mv,
  output logic signed [HDNG_W-1:0] dsrd_hdng,
  output logic                     r0_done,
  output logic                     r1_done,
  output logic [1:0]               gnt,
  output logic                     busy,
  output logic                     nav_err
);

  req_t [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0]              hp, mp, clr_h, clr_m;
  logic [NUM_REQ-1:0][HDNG_W-1:0]  hq;

  state_t             state, nxt;
  cmd_t               cmd_q, sel_cmd;
  logic [NUM_REQ-1:0] gnt_q, done_q;
  logic [HDNG_W-1:0]  dsrd_q;
  logic               sel_idx, do_grant, do_done, do_tmo, err_q;

  assign req[0] = '{hdng_req: r0_hdng_req, mv_req: r0_mv_req, hdng: r0_hdng};
  assign req[1] = '{hdng_req: r1_hdng_req, mv_req: r1_mv_req, hdng: r1_hdng};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lat
    nav_req_latch u_lat (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req[g]),
      .clr_hdng (clr_h[g]),
      .clr_mv   (clr_m[g]),
      .hdng_pend(hp[g]),
      .mv_pend  (mp[g]),
      .hdng_q   (hq[g])
    );
  end

`ifdef NAV_TMO_EN
  logic [23:0] tmo_cnt;

  // Timeout counter: zeroed when a command is granted, counts while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_cnt <= '0;
    else if (do_grant)         tmo_cnt <= '0;
    else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 24'd1;
  end
`else
  logic tmo_unused;
  assign tmo_unused = ^TMO_CYC;
`endif

  // Next state, owner/command selection and pending-bit clears.
  always_comb begin
    nxt      = state;
    do_grant = 1'b0;
    do_done  = 1'b0;
    do_tmo   = 1'b0;
    sel_idx  = 1'b0;
    sel_cmd  = CMD_HDNG;
    clr_h    = '0;
    clr_m    = '0;
    case (state)
      ST_IDLE: begin
        if (|(hp | mp)) begin
          do_grant = 1'b1;
          nxt      = ST_ISSUE;
          for (int i = NUM_REQ - 1; i >= 0; i--)
            if (hp[i] | mp[i]) sel_idx = 1'(i);
          sel_cmd         = hp[sel_idx] ? CMD_HDNG : CMD_MV;
          clr_h[sel_idx]  = hp[sel_idx];
          clr_m[sel_idx]  = ~hp[sel_idx];
        end
      end
      ST_ISSUE: nxt = ST_WAIT;
      ST_WAIT: begin
        if (mv_cmplt) begin
          do_done = 1'b1;
          nxt     = ST_IDLE;
        end
`ifdef NAV_TMO_EN
        else if (tmo_cnt == TMO_CYC - 24'd1) begin
          do_tmo = 1'b1;
          nxt    = ST_IDLE;
        end
`endif
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // State, grant, command, heading and completion/error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cmd_q  <= CMD_HDNG;
      gnt_q  <= GNT_NONE;
      dsrd_q <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= '0;
      err_q  <= do_tmo;
      if (do_grant) begin
        gnt_q <= GNT_R0 << sel_idx;
        cmd_q <= sel_cmd;
        if (sel_cmd == CMD_HDNG) dsrd_q <= hq[sel_idx];
      end
      if (do_done) done_q <= gnt_q;
      if (do_done || do_tmo) gnt_q <= GNT_NONE;
    end
  end

  assign strt_hdng = (state == ST_ISSUE) && (cmd_q == CMD_HDNG);
  assign strt_mv   = (state == ST_ISSUE) && (cmd_q == CMD_MV);
  assign busy      = (state != ST_IDLE);
  assign dsrd_hdng = dsrd_q;
  assign gnt       = gnt_q;
  assign r0_done   = done_q[0];
  assign r1_done   = done_q[1];
  assign nav_err   = err_q;

endmodule

// File: tb/tb_nav_arbiter.sv
// Scoreboard bench for nav_arbiter: stimulus pushes expected output events
// (kind, cycle, heading, grant); a negedge monitor pops and compares them.
module tb_nav_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0_hdng_req = 0, r0_mv_req = 0, r1_hdng_req = 0, r1_mv_req = 0;
  logic mv_cmplt = 0;
  logic signed [11:0] r0_hdng = '0, r1_hdng = '0;
  logic strt_hdng, strt_mv, r0_done, r1_done, busy, nav_err;
  logic signed [11:0] dsrd_hdng;
  logic [1:0] gnt;

  localparam logic [4:0] EV_SH = 5'b00001, EV_SM = 5'b00010, EV_D0 = 5'b00100,
                         EV_D1 = 5'b01000, EV_ER = 5'b10000;

  typedef struct {
    logic [4:0]  ev;
    int          c;
    logic [11:0] h;
    logic [1:0]  g;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   b;

  nav_arbiter #(.TMO_CYC(24'd100)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_hdng_req(r0_hdng_req), .r0_mv_req(r0_mv_req), .r0_hdng(r0_hdng),
    .r1_hdng_req(r1_hdng_req), .r1_mv_req(r1_mv_req), .r1_hdng(r1_hdng),
    .mv_cmplt(mv_cmplt), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .dsrd_hdng(dsrd_hdng), .r0_done(r0_done), .r1_done(r1_done),
    .gnt(gnt), .busy(busy), .nav_err(nav_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic exp_ev(input logic [4:0] ev, input int c, input logic [11:0] h,
                        input logic [1:0] g);
    q.push_back('{ev: ev, c: c, h: h, g: g});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every output event must match the head of the expected queue.
  always @(negedge clk) begin
    logic [4:0] ev;
    exp_t e;
    ev = {nav_err, r1_done, r0_done, strt_mv, strt_hdng};
    if (ev != 5'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got ev=%b gnt=%b hdng=%h at cycle %0d, want none",
                 ev, gnt, dsrd_hdng, cyc);
      end else begin
        e = q.pop_front();
        if (ev !== e.ev || cyc != e.c || dsrd_hdng !== e.h || gnt !== e.g) begin
          errors++;
          $display("FAIL event: got ev=%b cyc=%0d hdng=%h gnt=%b, want ev=%b cyc=%0d hdng=%h gnt=%b",
                   ev, cyc, dsrd_hdng, gnt, e.ev, e.c, e.h, e.g);
        end
      end
    end
  end

  initial begin
    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    chk("reset_outputs", {16'd0, strt_hdng, strt_mv, dsrd_hdng, r0_done, r1_done, gnt, busy, nav_err},
        32'd0);
    rst_n = 1'b1;

    // r1 heading 3FF, latency N+2, done one cycle after mv_cmplt.
    b = cyc + 2;
    at(b);      r1_hdng_req = 1; r1_hdng = 12'h3FF;
    exp_ev(EV_SH, b + 2, 12'h3FF, 2'b10);
    exp_ev(EV_D1, b + 11, 12'h3FF, 2'b00);
    at(b + 1);  r1_hdng_req = 0;
    at(b + 3);  chk("busy_in_wait", {31'd0, busy}, 32'd1);
    at(b + 10); mv_cmplt = 1;
    at(b + 11); mv_cmplt = 0;

    // Simultaneous moves: r0 first, r1 two cycles after r0's completion.
    b = cyc + 3;
    at(b);     r0_mv_req = 1; r1_mv_req = 1;
    exp_ev(EV_SM, b + 2, 12'h3FF, 2'b01);
    exp_ev(EV_D0, b + 6, 12'h3FF, 2'b00);
    exp_ev(EV_SM, b + 7, 12'h3FF, 2'b10);
    exp_ev(EV_D1, b + 10, 12'h3FF, 2'b00);
    at(b + 1); r0_mv_req = 0; r1_mv_req = 0;
    at(b + 5); mv_cmplt = 1;
    at(b + 6); mv_cmplt = 0;
    at(b + 9); mv_cmplt = 1;
    at(b + 10); mv_cmplt = 0;

    // Same requester heading + move: heading first, move after completion.
    b = cyc + 3;
    at(b);     r1_hdng_req = 1; r1_mv_req = 1; r1_hdng = 12'h7FF;
    exp_ev(EV_SH, b + 2, 12'h7FF, 2'b10);
    exp_ev(EV_D1, b + 5, 12'h7FF, 2'b00);
    exp_ev(EV_SM, b + 6, 12'h7FF, 2'b10);
    exp_ev(EV_D1, b + 9, 12'h7FF, 2'b00);
    at(b + 1); r1_hdng_req = 0; r1_mv_req = 0;
    at(b + 4); mv_cmplt = 1;
    at(b + 5); mv_cmplt = 0;
    at(b + 8); mv_cmplt = 1;
    at(b + 9); mv_cmplt = 0;

    // r0 heading repeated during r1 ownership: one command, newest heading.
    // mv_cmplt during ISSUE and during IDLE must be ignored.
    b = cyc + 3;
    at(b);      r1_mv_req = 1;
    exp_ev(EV_SM, b + 2, 12'h7FF, 2'b10);
    exp_ev(EV_D1, b + 9, 12'h7FF, 2'b00);
    exp_ev(EV_SH, b + 10, 12'hC00, 2'b01);
    exp_ev(EV_D0, b + 13, 12'hC00, 2'b00);
    at(b + 1);  r1_mv_req = 0;
    at(b + 3);  r0_hdng_req = 1; r0_hdng = 12'h7FF;
    at(b + 4);  r0_hdng_req = 0;
    at(b + 5);  r0_hdng_req = 1; r0_hdng = 12'hC00;
    at(b + 6);  r0_hdng_req = 0;
    at(b + 8);  mv_cmplt = 1;
    at(b + 9);  mv_cmplt = 0;
    at(b + 10); mv_cmplt = 1;
    at(b + 11); mv_cmplt = 0;
    at(b + 12); mv_cmplt = 1;
    at(b + 13); mv_cmplt = 0;
    at(b + 16); mv_cmplt = 1;
    at(b + 17); mv_cmplt = 0;
    at(b + 18); chk("idle_after_ignored_cmplt", {29'd0, busy, gnt}, 32'd0);

    // Pulse in the same cycle the pending bit is cleared is re-queued.
    b = cyc + 3;
    at(b);     r0_mv_req = 1;
    exp_ev(EV_SM, b + 2, 12'hC00, 2'b01);
    exp_ev(EV_D0, b + 5, 12'hC00, 2'b00);
    exp_ev(EV_SM, b + 6, 12'hC00, 2'b01);
    exp_ev(EV_D0, b + 9, 12'hC00, 2'b00);
    at(b + 2); r0_mv_req = 0;
    at(b + 4); mv_cmplt = 1;
    at(b + 5); mv_cmplt = 0;
    at(b + 8); mv_cmplt = 1;
    at(b + 9); mv_cmplt = 0;

    // No completion: timeout (if enabled) or indefinite WAIT; then reset
    // with an r0 move pending must discard everything.
    b = cyc + 3;
    at(b);       r0_hdng_req = 1; r0_hdng = 12'h123;
    exp_ev(EV_SH, b + 2, 12'h123, 2'b01);
`ifdef NAV_TMO_EN
    exp_ev(EV_ER, b + 103, 12'h123, 2'b00);
    exp_ev(EV_SM, b + 112, 12'h123, 2'b01);
`endif
    at(b + 1);   r0_hdng_req = 0;
    at(b + 110); r0_mv_req = 1;
    at(b + 111); r0_mv_req = 0;
    at(b + 140); chk("still_waiting", {29'd0, busy, gnt}, 32'b101);
    rst_n = 1'b0;
    at(b + 141);
    chk("reset_mid_op", {16'd0, strt_hdng, strt_mv, dsrd_hdng, r0_done, r1_done, gnt, busy, nav_err},
        32'd0);
    at(b + 143); rst_n = 1'b1;
    at(b + 170);
    chk("idle_after_reset", {17'd0, busy, gnt, dsrd_hdng}, 32'd0);

    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got cycle %0d want under 10000", cyc);
    $fatal(1);
  end

endmodule
